// File: rtl/split_pulse_arbiter.sv
// split_pulse_arbiter
// Shares one SPLIT cell input among N_REQ requesters. Grants are round-robin,
// and each grant emits one SFQ pulse as a toggle of a_out. Successive toggles
// are spaced by the cell's critical time. An owner-ID FIFO records outstanding
// pulses. A pulse retires when both split outputs (q0, q1) have toggled back,
// and the owner then sees done. Protocol violations set a sticky err.
// N_REQ must be 2..8. MAX_OUT must be a power of two and at least 2.
module split_pulse_arbiter #(
  parameter int N_REQ     = 4,
  parameter int CT_CYCLES = 4,
  parameter int MAX_OUT   = 4,
  parameter int TIMEOUT   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [N_REQ-1:0] done,
  output logic             a_out,
  input  logic             q0_in,
  input  logic             q1_in,
  output logic             busy,
  output logic             err,
  output logic [15:0]      pulse_cnt
);

  localparam int ID_W   = $clog2(N_REQ);
  localparam int PTR_W  = $clog2(MAX_OUT);
  localparam int CNT_W  = $clog2(MAX_OUT + 1);
  localparam int HOLD_W = (CT_CYCLES > 1) ? $clog2(CT_CYCLES) : 1;
  localparam int AGE_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    HOLD
  } state_t;

  // Requester index (v mod N_REQ), used for the round-robin wrap.
  function automatic logic [ID_W-1:0] wrap_id(input int v);
    return ID_W'(v % N_REQ);
  endfunction

  function automatic logic [N_REQ-1:0] one_hot(input logic [ID_W-1:0] id);
    return N_REQ'(1) << id;
  endfunction

  // Issue-side state
  state_t            state_q, state_d;
  logic [HOLD_W-1:0] holdoff_q, holdoff_d;
  logic [ID_W-1:0]   rr_ptr;
  logic              any_req;
  logic [ID_W-1:0]   win_id;
  logic              issue;

  // Owner-ID FIFO
  logic [ID_W-1:0]   mem [MAX_OUT];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  fifo_cnt, fifo_cnt_d;
  logic              fifo_full, fifo_nempty;

  // Return path
  logic              q0_prev, q1_prev;
  logic [CNT_W-1:0]  q0_pend, q1_pend, q0_pend_d, q1_pend_d;
  logic [CNT_W-1:0]  eff0, eff1;
  logic              e0, e1, acc0, acc1, bad0, bad1;
  logic              match_pop, timeout_pop, pop;
  logic [AGE_W-1:0]  age;

  assign fifo_full   = (fifo_cnt == CNT_W'(MAX_OUT));
  assign fifo_nempty = (fifo_cnt != '0);
  assign busy        = fifo_nempty || (state_q != IDLE);

  // Round-robin pick: first asserted req at or after rr_ptr, wrapping.
  // NOTE: every variable written here gets a default first; a path that
  // skipped an assignment would infer a latch.
  always_comb begin
    any_req = 1'b0;
    win_id  = '0;
    // Walk from the farthest candidate back to rr_ptr, so the nearest one wins.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[wrap_id(int'(rr_ptr) + k)]) begin
        any_req = 1'b1;
        win_id  = wrap_id(int'(rr_ptr) + k);
      end
    end
  end

  // Next state: issue when the holdoff has expired and the FIFO has room;
  // otherwise count the critical-time holdoff down toward IDLE.
  always_comb begin
    state_d   = state_q;
    holdoff_d = holdoff_q;
    issue     = 1'b0;
    if (holdoff_q == '0 && any_req && !fifo_full) begin
      issue     = 1'b1;
      state_d   = ISSUE;
      holdoff_d = HOLD_W'(CT_CYCLES - 1);
    end else begin
      case (state_q)
        IDLE: begin
          state_d   = IDLE;
          holdoff_d = '0;
        end
        ISSUE, HOLD: begin
          if (holdoff_q <= HOLD_W'(1)) begin
            state_d   = IDLE;
            holdoff_d = '0;
          end else begin
            state_d   = HOLD;
            holdoff_d = holdoff_q - HOLD_W'(1);
          end
        end
        default: begin
          state_d   = IDLE;
          holdoff_d = '0;
        end
      endcase
    end
  end

  // FSM state and holdoff registers.
  // NOTE: sequential state uses non-blocking assignments, so every flop
  // samples the values from before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      holdoff_q <= '0;
    end else begin
      state_q   <= state_d;
      holdoff_q <= holdoff_d;
    end
  end

  // Return-path decisions. Each q edge is accepted only while its pending
  // count is below FIFO occupancy. An edge arriving with no pulse left to
  // match is dropped and flagged. Same-cycle edges count toward the pop.
  always_comb begin
    e0          = q0_in ^ q0_prev;
    e1          = q1_in ^ q1_prev;
    acc0        = e0 && (q0_pend < fifo_cnt);
    acc1        = e1 && (q1_pend < fifo_cnt);
    bad0        = e0 && !acc0;
    bad1        = e1 && !acc1;
    eff0        = q0_pend + CNT_W'(acc0);
    eff1        = q1_pend + CNT_W'(acc1);
    match_pop   = fifo_nempty && (eff0 != '0) && (eff1 != '0);
    timeout_pop = fifo_nempty && !match_pop && (age == AGE_W'(TIMEOUT));
    pop         = match_pop || timeout_pop;
    fifo_cnt_d  = fifo_cnt + CNT_W'(issue) - CNT_W'(pop);
    if (timeout_pop) begin
      q0_pend_d = '0;
      q1_pend_d = '0;
    end else begin
      q0_pend_d = eff0 - CNT_W'(match_pop);
      q1_pend_d = eff1 - CNT_W'(match_pop);
    end
  end

  // Issue datapath: grant pulse, a_out toggle, pulse counter, RR pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt       <= '0;
      a_out     <= 1'b0;
      pulse_cnt <= '0;
      rr_ptr    <= '0;
    end else begin
      gnt <= '0;
      if (issue) begin
        gnt       <= one_hot(win_id);
        a_out     <= ~a_out;
        pulse_cnt <= pulse_cnt + 16'd1;
        rr_ptr    <= wrap_id(int'(win_id) + 1);
      end
    end
  end

  // Owner-ID storage. Only written when a pulse is issued.
  // NOTE: the storage array has no reset. Clearing the pointers and the
  // count empties the FIFO, and stale entries are never read.
  always_ff @(posedge clk) begin
    if (issue) mem[wr_ptr] <= win_id;
  end

  // FIFO pointers, pending counters, head age, done pulse and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      q0_prev  <= 1'b0;
      q1_prev  <= 1'b0;
      q0_pend  <= '0;
      q1_pend  <= '0;
      age      <= '0;
      done     <= '0;
      err      <= 1'b0;
    end else begin
      q0_prev  <= q0_in;
      q1_prev  <= q1_in;
      q0_pend  <= q0_pend_d;
      q1_pend  <= q1_pend_d;
      fifo_cnt <= fifo_cnt_d;
      done     <= '0;
      if (issue) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      if (match_pop) done <= one_hot(mem[rd_ptr]);
      // The age restarts whenever the head changes or the FIFO is empty.
      if (!fifo_nempty || pop) age <= '0;
      else                     age <= age + AGE_W'(1);
      if (bad0 || bad1 || timeout_pop) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_split_pulse_arbiter.sv
// Directed testbench for split_pulse_arbiter (N_REQ=4, CT_CYCLES=4,
// MAX_OUT=4, TIMEOUT=32). The q0/q1 inputs come from a loopback delay line
// fed by a_out, or are driven by hand. Cycle c is the cycle that starts at
// the c-th posedge after stimulus starts. Outputs are sampled 1 time unit
// after that edge.
module tb_split_pulse_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [3:0]  gnt, done;
  logic        a_out;
  logic        q0_in = 1'b0;
  logic        q1_in = 1'b0;
  logic        busy, err;
  logic [15:0] pulse_cnt;

  int pass_cnt  = 0;
  int check_cnt = 0;
  int cyc       = 0;

  // Loopback control. A tap of D makes a q line act as if it toggled
  // D edges after the a_out toggle.
  logic        lb_en       = 1'b0;
  logic        man_q0      = 1'b0;
  logic        man_q1      = 1'b0;
  logic        drop_on_gnt = 1'b1;
  int          tap0        = 7;
  int          tap1        = 7;
  logic [31:0] dl          = '0;

  split_pulse_arbiter #(
    .N_REQ(4), .CT_CYCLES(4), .MAX_OUT(4), .TIMEOUT(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .done(done),
    .a_out(a_out), .q0_in(q0_in), .q1_in(q1_in), .busy(busy),
    .err(err), .pulse_cnt(pulse_cnt)
  );

  always #5 clk = ~clk;

  // q inputs change on the falling edge, so the DUT samples them cleanly.
  always @(negedge clk) begin
    if (lb_en) begin
      dl    = {dl[30:0], a_out};
      q0_in = dl[tap0];
      q1_in = dl[tap1];
    end else begin
      dl    = '0;
      q0_in = man_q0;
      q1_in = man_q1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (drop_on_gnt) req = req & ~gnt;
  endtask

  task automatic apply_reset();
    rst_n  = 1'b0;
    req    = '0;
    lb_en  = 1'b0;
    man_q0 = 1'b0;
    man_q1 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    check_cnt++; if (gnt !== 4'b0)        $display("FAIL reset_gnt got %b exp 0000", gnt); else pass_cnt++;
    check_cnt++; if (done !== 4'b0)       $display("FAIL reset_done got %b exp 0000", done); else pass_cnt++;
    check_cnt++; if (a_out !== 1'b0)      $display("FAIL reset_a_out got %b exp 0", a_out); else pass_cnt++;
    check_cnt++; if (busy !== 1'b0)       $display("FAIL reset_busy got %b exp 0", busy); else pass_cnt++;
    check_cnt++; if (err !== 1'b0)        $display("FAIL reset_err got %b exp 0", err); else pass_cnt++;
    check_cnt++; if (pulse_cnt !== 16'd0) $display("FAIL reset_pulse_cnt got %0d exp 0", pulse_cnt); else pass_cnt++;
    apply_reset();
    for (int c = 1; c <= 3; c++) begin
      step();
      check_cnt++; if (gnt !== 4'b0 || busy !== 1'b0) $display("FAIL idle_after_reset c%0d gnt %b busy %b exp 0000/0", cyc, gnt, busy); else pass_cnt++;
    end
  endtask

  task automatic test_single();
    logic [3:0] exp_g, exp_d;
    apply_reset();
    tap0 = 7; tap1 = 7; lb_en = 1'b1; drop_on_gnt = 1'b1;
    req = 4'b0001;
    check_cnt++; if (a_out !== 1'b0) $display("FAIL single_a_out_before got %b exp 0", a_out); else pass_cnt++;
    for (int c = 1; c <= 10; c++) begin
      step();
      exp_g = (c == 1) ? 4'b0001 : 4'b0000;
      exp_d = (c == 9) ? 4'b0001 : 4'b0000;
      check_cnt++; if (gnt !== exp_g)  $display("FAIL single_gnt c%0d got %b exp %b", cyc, gnt, exp_g); else pass_cnt++;
      check_cnt++; if (done !== exp_d) $display("FAIL single_done c%0d got %b exp %b", cyc, done, exp_d); else pass_cnt++;
      if (c == 1) begin
        check_cnt++; if (a_out !== 1'b1) $display("FAIL single_a_out_toggle got %b exp 1", a_out); else pass_cnt++;
      end
    end
    check_cnt++; if (pulse_cnt !== 16'd1) $display("FAIL single_pulse_cnt got %0d exp 1", pulse_cnt); else pass_cnt++;
    check_cnt++; if (err !== 1'b0)        $display("FAIL single_err got %b exp 0", err); else pass_cnt++;
    check_cnt++; if (busy !== 1'b0)       $display("FAIL single_busy_end got %b exp 0", busy); else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g, exp_d;
    apply_reset();
    tap0 = 7; tap1 = 7; lb_en = 1'b1; drop_on_gnt = 1'b1;
    req = 4'b1111;
    for (int c = 1; c <= 24; c++) begin
      step();
      exp_g = (c == 1) ? 4'b0001 : (c == 5) ? 4'b0010 : (c == 9)  ? 4'b0100 : (c == 13) ? 4'b1000 : 4'b0000;
      exp_d = (c == 9) ? 4'b0001 : (c == 13) ? 4'b0010 : (c == 17) ? 4'b0100 : (c == 21) ? 4'b1000 : 4'b0000;
      check_cnt++; if (gnt !== exp_g)  $display("FAIL rr_gnt c%0d got %b exp %b", cyc, gnt, exp_g); else pass_cnt++;
      check_cnt++; if (done !== exp_d) $display("FAIL rr_done c%0d got %b exp %b", cyc, done, exp_d); else pass_cnt++;
    end
    check_cnt++; if (pulse_cnt !== 16'd4) $display("FAIL rr_pulse_cnt got %0d exp 4", pulse_cnt); else pass_cnt++;
    check_cnt++; if (err !== 1'b0)        $display("FAIL rr_err got %b exp 0", err); else pass_cnt++;
  endtask

  task automatic test_full_timeout();
    logic [3:0] exp_g;
    apply_reset();
    lb_en = 1'b0; drop_on_gnt = 1'b0;
    req = 4'b1111;
    for (int c = 1; c <= 35; c++) begin
      step();
      exp_g = (c == 1) ? 4'b0001 : (c == 5) ? 4'b0010 : (c == 9) ? 4'b0100 :
              (c == 13) ? 4'b1000 : (c == 35) ? 4'b0001 : 4'b0000;
      check_cnt++; if (gnt !== exp_g)  $display("FAIL full_gnt c%0d got %b exp %b", cyc, gnt, exp_g); else pass_cnt++;
      check_cnt++; if (done !== 4'b0)  $display("FAIL full_done c%0d got %b exp 0000", cyc, done); else pass_cnt++;
      if (c == 20 || c == 33) begin
        check_cnt++; if (busy !== 1'b1) $display("FAIL full_busy c%0d got %b exp 1", cyc, busy); else pass_cnt++;
      end
      if (c == 33) begin
        check_cnt++; if (err !== 1'b0) $display("FAIL timeout_early c%0d got %b exp 0", cyc, err); else pass_cnt++;
      end
      if (c == 34) begin
        check_cnt++; if (err !== 1'b1) $display("FAIL timeout_err c%0d got %b exp 1", cyc, err); else pass_cnt++;
      end
    end
    req = '0;
    drop_on_gnt = 1'b1;
  endtask

  task automatic test_spurious();
    logic [3:0] exp_g;
    apply_reset();
    lb_en = 1'b0; drop_on_gnt = 1'b1;
    step();
    man_q0 = 1'b1;
    step();
    check_cnt++; if (err !== 1'b1)  $display("FAIL spurious_err got %b exp 1", err); else pass_cnt++;
    check_cnt++; if (done !== 4'b0) $display("FAIL spurious_done got %b exp 0000", done); else pass_cnt++;
    req = 4'b0001;
    step();
    check_cnt++; if (gnt !== 4'b0001) $display("FAIL spurious_gnt got %b exp 0001", gnt); else pass_cnt++;
    man_q1 = 1'b1;
    // Only q1 has returned; a stray q0 count left over would retire it here.
    for (int c = 0; c < 3; c++) begin
      step();
      check_cnt++; if (done !== 4'b0) $display("FAIL spurious_pend c%0d got %b exp 0000", cyc, done); else pass_cnt++;
    end
    man_q0 = 1'b0;
    step();
    exp_g = 4'b0001;
    check_cnt++; if (done !== exp_g) $display("FAIL spurious_late_done got %b exp %b", done, exp_g); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_g, exp_d;
    apply_reset();
    tap0 = 7; tap1 = 4; lb_en = 1'b1; drop_on_gnt = 1'b1;
    req = 4'b0001;
    for (int c = 1; c <= 19; c++) begin
      step();
      exp_g = (c == 1) ? 4'b0001 : (c == 9)  ? 4'b0010 : 4'b0000;
      exp_d = (c == 9) ? 4'b0001 : (c == 17) ? 4'b0010 : 4'b0000;
      check_cnt++; if (gnt !== exp_g)  $display("FAIL b2b_gnt c%0d got %b exp %b", cyc, gnt, exp_g); else pass_cnt++;
      check_cnt++; if (done !== exp_d) $display("FAIL b2b_done c%0d got %b exp %b", cyc, done, exp_d); else pass_cnt++;
      if (c == 8) req = 4'b0010;
      if (c == 12) begin
        check_cnt++; if (busy !== 1'b1) $display("FAIL b2b_busy_mid got %b exp 1", busy); else pass_cnt++;
      end
    end
    check_cnt++; if (busy !== 1'b0)       $display("FAIL b2b_busy_end got %b exp 0", busy); else pass_cnt++;
    check_cnt++; if (err !== 1'b0)        $display("FAIL b2b_err got %b exp 0", err); else pass_cnt++;
    check_cnt++; if (pulse_cnt !== 16'd2) $display("FAIL b2b_pulse_cnt got %0d exp 2", pulse_cnt); else pass_cnt++;
  endtask

  task automatic test_reset_midstream();
    logic [3:0] exp_g;
    apply_reset();
    tap0 = 20; tap1 = 20; lb_en = 1'b1; drop_on_gnt = 1'b1;
    req = 4'b0111;
    for (int c = 1; c <= 11; c++) begin
      step();
      exp_g = (c == 1) ? 4'b0001 : (c == 5) ? 4'b0010 : (c == 9) ? 4'b0100 : 4'b0000;
      check_cnt++; if (gnt !== exp_g) $display("FAIL mid_gnt c%0d got %b exp %b", cyc, gnt, exp_g); else pass_cnt++;
    end
    check_cnt++; if (busy !== 1'b1) $display("FAIL mid_busy_before got %b exp 1", busy); else pass_cnt++;
    rst_n = 1'b0;
    req   = '0;
    #1;
    check_cnt++; if (a_out !== 1'b0)      $display("FAIL mid_rst_a_out got %b exp 0", a_out); else pass_cnt++;
    check_cnt++; if (busy !== 1'b0)       $display("FAIL mid_rst_busy got %b exp 0", busy); else pass_cnt++;
    check_cnt++; if (pulse_cnt !== 16'd0) $display("FAIL mid_rst_pulse_cnt got %0d exp 0", pulse_cnt); else pass_cnt++;
    check_cnt++; if (gnt !== 4'b0 || done !== 4'b0 || err !== 1'b0)
      $display("FAIL mid_rst_outs gnt %b done %b err %b exp 0000/0000/0", gnt, done, err); else pass_cnt++;
    step();
    step();
    rst_n = 1'b1;
    for (int c = 14; c <= 40; c++) begin
      step();
      check_cnt++; if (done !== 4'b0) $display("FAIL mid_done c%0d got %b exp 0000", cyc, done); else pass_cnt++;
      if (c == 21) begin
        check_cnt++; if (err !== 1'b0) $display("FAIL mid_err_early c%0d got %b exp 0", cyc, err); else pass_cnt++;
      end
      if (c == 22) begin
        check_cnt++; if (err !== 1'b1) $display("FAIL mid_err_unmatched c%0d got %b exp 1", cyc, err); else pass_cnt++;
      end
    end
    check_cnt++; if (busy !== 1'b0 || pulse_cnt !== 16'd0)
      $display("FAIL mid_end busy %b pulse_cnt %0d exp 0/0", busy, pulse_cnt); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full_timeout();
    test_spurious();
    test_back_to_back();
    test_reset_midstream();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
